// File: rtl/el2_regfile_snapshot_streamer_if.sv
// el2_regfile_if: register-file observation bundle, 26 x 32-bit GPR/TLU values exposed by the core.
interface el2_regfile_if;
    logic [31:0] ra, sp, fp, a0, a1, a2, a3, a4, a5, a6, a7;
    logic [31:0] pc, npc, mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip;
    logic [31:0] mcyclel, mcycleh, minstretl, minstreth, mrac;
    modport master (
        output ra, sp, fp, a0, a1, a2, a3, a4, a5, a6, a7,
               pc, npc, mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip,
               mcyclel, mcycleh, minstretl, minstreth, mrac
    );
    modport slave (
        input ra, sp, fp, a0, a1, a2, a3, a4, a5, a6, a7,
              pc, npc, mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip,
              mcyclel, mcycleh, minstretl, minstreth, mrac
    );
    modport veer_rf_sink (
        input ra, sp, fp, a0, a1, a2, a3, a4, a5, a6, a7,
              pc, npc, mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip,
              mcyclel, mcycleh, minstretl, minstreth, mrac
    );
endinterface

// File: rtl/el2_regfile_snapshot_streamer.sv
// el2_regfile_snapshot_streamer: captures all 26 observed registers on snap_req and streams the SEL_MASK subset.
// Define EL2_RF_SNAPSHOT_TIMESTAMP_EN to prefix each stream with a capture-timestamp header beat (out_idx=31).
module el2_regfile_snapshot_streamer #(
    parameter logic [25:0] SEL_MASK = 26'h3FF_FFFF
) (
    input  logic                       clk,
    input  logic                       rst_l,
    el2_regfile_if.veer_rf_sink        rf,
    input  logic                       snap_req,
    output logic                       snap_busy,
    output logic                       snap_drop,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [4:0]                 out_idx,
    output logic                       out_last
);
    localparam logic [4:0] HDR_IDX = 5'd31;

    if (SEL_MASK == '0) begin : g_bad_mask
        $error("SEL_MASK must be nonzero");
    end

    // Lowest selected index above i; HDR_IDX acts as "before index 0" and as the none-left result.
    function automatic logic [4:0] sel_after(input logic [4:0] i);
        logic [4:0] r;
        r = HDR_IDX;
        for (int j = 25; j >= 0; j--)
            if (SEL_MASK[j] && (i == HDR_IDX || j > int'(i))) r = 5'(j);
        return r;
    endfunction

    typedef enum logic {IDLE, STREAM} state_t;
    state_t state, state_nxt;
    logic [4:0] idx, idx_nxt;
    logic [31:0] shadow [26];
    logic [31:0] cap [26];
    logic [31:0] ts_cap;
    logic fire, capture, drop_nxt;

`ifdef EL2_RF_SNAPSHOT_TIMESTAMP_EN
    localparam logic [4:0] START_IDX = HDR_IDX;
    logic [31:0] ts;
    always_ff @(posedge clk or negedge rst_l)
        if (!rst_l) begin
            ts     <= '0;
            ts_cap <= '0;
        end else begin
            ts <= ts + 32'd1;
            if (capture) ts_cap <= ts;
        end
`else
    localparam logic [4:0] START_IDX = sel_after(HDR_IDX);
    assign ts_cap = '0;
`endif

    assign cap = '{rf.ra, rf.sp, rf.fp, rf.a0, rf.a1, rf.a2, rf.a3, rf.a4, rf.a5, rf.a6, rf.a7,
                   rf.pc, rf.npc, rf.mstatus, rf.mie, rf.mtvec, rf.mscratch, rf.mepc, rf.mcause,
                   rf.mtval, rf.mip, rf.mcyclel, rf.mcycleh, rf.minstretl, rf.minstreth, rf.mrac};

    assign out_valid = state == STREAM;
    assign snap_busy = out_valid;
    assign out_idx   = out_valid ? idx : '0;
    assign out_last  = out_valid && sel_after(idx) == HDR_IDX;
    assign out_data  = !out_valid ? '0 : idx == HDR_IDX ? ts_cap : shadow[idx];

    // A request coinciding with the final handshake chains straight into a new stream.
    always_comb begin
        fire      = out_valid && out_ready;
        capture   = snap_req && (state == IDLE || (fire && out_last));
        drop_nxt  = snap_req && state == STREAM && !capture;
        state_nxt = state;
        idx_nxt   = idx;
        if (capture) begin
            state_nxt = STREAM;
            idx_nxt   = START_IDX;
        end else if (fire && out_last) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else if (fire) begin
            idx_nxt   = sel_after(idx);
        end
    end

    always_ff @(posedge clk or negedge rst_l)
        if (!rst_l) begin
            state     <= IDLE;
            idx       <= '0;
            snap_drop <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            snap_drop <= drop_nxt;
        end

    always_ff @(posedge clk or negedge rst_l)
        if (!rst_l) shadow <= '{default: '0};
        else if (capture) shadow <= cap;
endmodule

// File: tb/tb_el2_regfile_snapshot_streamer.sv
// tb_el2_regfile_snapshot_streamer: three mask variants checked against a queue-of-beats reference model.
module tb_el2_regfile_snapshot_streamer;
    localparam logic [2:0][25:0] MASKS = {26'h2A5_00F3, 26'h000_0801, 26'h3FF_FFFF};

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic clk = 0, rst_l = 0, snap_req = 0;
    logic [2:0] rdy = '0, ov, busy, drop, last;
    logic [31:0] od [3];
    logic [4:0] oi [3];
    logic [31:0] rfv [26];
    beat_t q [3][$];
    bit edrop [3];
    int unsigned ts;
    int total = 0, bad = 0;

    el2_regfile_if rf();

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        el2_regfile_snapshot_streamer #(.SEL_MASK(MASKS[g])) dut (
            .clk(clk), .rst_l(rst_l), .rf(rf), .snap_req(snap_req),
            .snap_busy(busy[g]), .snap_drop(drop[g]), .out_valid(ov[g]), .out_ready(rdy[g]),
            .out_data(od[g]), .out_idx(oi[g]), .out_last(last[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apply_rf();
        rf.ra = rfv[0];  rf.sp = rfv[1];  rf.fp = rfv[2];
        rf.a0 = rfv[3];  rf.a1 = rfv[4];  rf.a2 = rfv[5];  rf.a3 = rfv[6];
        rf.a4 = rfv[7];  rf.a5 = rfv[8];  rf.a6 = rfv[9];  rf.a7 = rfv[10];
        rf.pc = rfv[11]; rf.npc = rfv[12]; rf.mstatus = rfv[13]; rf.mie = rfv[14];
        rf.mtvec = rfv[15]; rf.mscratch = rfv[16]; rf.mepc = rfv[17]; rf.mcause = rfv[18];
        rf.mtval = rfv[19]; rf.mip = rfv[20]; rf.mcyclel = rfv[21]; rf.mcycleh = rfv[22];
        rf.minstretl = rfv[23]; rf.minstreth = rfv[24]; rf.mrac = rfv[25];
    endtask

    task automatic rand_rf();
        for (int i = 0; i < 26; i++) rfv[i] = $urandom;
        apply_rf();
    endtask

    // The snapshot is the list of beats the stream must produce, fixed at capture time.
    task automatic build(input int k);
`ifdef EL2_RF_SNAPSHOT_TIMESTAMP_EN
        q[k].push_back('{5'd31, 32'(ts)});
`endif
        for (int i = 0; i < 26; i++)
            if (MASKS[k][i]) q[k].push_back('{5'(i), rfv[i]});
    endtask

    task automatic check(input int k);
        string p;
        p = $sformatf("d%0d c%0d", k, ts);
        if (q[k].size() > 0) begin
            chk({p, " valid"}, 32'(ov[k]), 32'd1);
            chk({p, " busy"}, 32'(busy[k]), 32'd1);
            chk({p, " idx"}, 32'(oi[k]), 32'(q[k][0].idx));
            chk({p, " data"}, od[k], q[k][0].data);
            chk({p, " last"}, 32'(last[k]), 32'(q[k].size() == 1));
        end else begin
            chk({p, " valid"}, 32'(ov[k]), 32'd0);
            chk({p, " busy"}, 32'(busy[k]), 32'd0);
        end
        chk({p, " drop"}, 32'(drop[k]), 32'(edrop[k]));
    endtask

    task automatic step(input int k);
        bit v, acc, lst;
        v   = q[k].size() > 0;
        lst = q[k].size() == 1;
        acc = v && rdy[k];
        if (acc) void'(q[k].pop_front());
        edrop[k] = 0;
        if (snap_req) begin
            if (!v || (acc && lst)) build(k);
            else edrop[k] = 1;
        end
    endtask

    task automatic cycle(input bit r, input logic [2:0] rd, input bit new_rf);
        for (int k = 0; k < 3; k++) check(k);
        snap_req = r;
        rdy = rd;
        if (new_rf) rand_rf();
        for (int k = 0; k < 3; k++) step(k);
        ts++;
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            edrop[k] = 0;
        end
    endtask

    initial begin
        rand_rf();
        snap_req = 1;
        rdy = '1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst d%0d valid", k), 32'(ov[k]), 32'd0);
            chk($sformatf("rst d%0d data", k), od[k], 32'd0);
            chk($sformatf("rst d%0d idx", k), 32'(oi[k]), 32'd0);
            chk($sformatf("rst d%0d busy", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst d%0d drop", k), 32'(drop[k]), 32'd0);
        end
        snap_req = 0;
        clear_model();
        for (int i = 0; i < 26; i++) rfv[i] = 32'hA000_0000 + 32'(i);
        apply_rf();
        rst_l = 1;
        ts = 0;
        // Directed: capture at 10, rf changes at 12, mid-stream request at 20, back-to-back at 36.
        for (int c = 0; c < 70; c++)
            cycle(c == 10 || c == 20 || c == 36, 3'b111, c == 12);
        // Backpressure pattern 1,0,0,1 on every instance.
        for (int c = 0; c < 130; c++)
            cycle(c == 2, (c % 4 == 0 || c % 4 == 3) ? 3'b111 : 3'b000, 1'b1);
        // Randomized requests, readiness and register values.
        for (int c = 0; c < 2000; c++)
            cycle($urandom_range(0, 11) == 0, 3'($urandom), 1'b1);
        // Reset in the middle of a stream.
        cycle(1'b1, 3'b111, 1'b1);
        repeat (3) cycle(1'b0, 3'b111, 1'b1);
        rst_l = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midrst d%0d valid", k), 32'(ov[k]), 32'd0);
            chk($sformatf("midrst d%0d last", k), 32'(last[k]), 32'd0);
            chk($sformatf("midrst d%0d data", k), od[k], 32'd0);
        end
        clear_model();
        snap_req = 0;
        @(negedge clk);
        rst_l = 1;
        ts = 0;
        for (int c = 0; c < 200; c++)
            cycle(c == 5 || $urandom_range(0, 15) == 0, 3'($urandom), 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
